btn_pair_conditioner: RTL

//   Upstream input stage for the two-input tutorial FSM: turns raw push-button levels (a, b) into clean,

---
 rtl/btn_pair_conditioner.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/btn_pair_conditioner.sv
// Two-channel button front end: 2-flop sync, per-channel debounce FSM, then a pairing
// stage that merges presses landing within COIN_WIN cycles into one a=b=1 command pulse.
module btn_pair_conditioner #(
  parameter int DB_CYCLES  = 16,
  parameter int CNT_W      = 20,
  parameter int COIN_WIN   = 3,
  parameter int PULSE_MODE = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_a_raw,
  input  logic btn_b_raw,
  output logic a,
  output logic b,
  output logic a_db,
  output logic b_db
);

  typedef enum logic [1:0] {IDLE_LO, WAIT_HI, IDLE_HI, WAIT_LO} db_state_e;
  typedef enum logic [1:0] {P_IDLE, P_HOLD_A, P_HOLD_B} pair_state_e;

  localparam int TW = $clog2(COIN_WIN + 2);

  logic [1:0] raw;
  logic [1:0] sync1_q, sync2_q;
  logic [1:0] db_q, db_d;
  logic [1:0] ev_q;

  assign raw = {btn_b_raw, btn_a_raw};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      db_q    <= '0;
      ev_q    <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      db_q    <= db_d;
      ev_q    <= db_d & ~db_q;  // press = accepted 0->1 transition only
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_db
      db_state_e        st_q, st_d;
      logic [CNT_W-1:0] cnt_q, cnt_d;
      logic             lvl_d;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          st_q  <= IDLE_LO;
          cnt_q <= '0;
        end else begin
          st_q  <= st_d;
          cnt_q <= cnt_d;
        end
      end

      // A full stability run is accepted even if the synced level flips on the accept edge.
      always_comb begin
        st_d  = st_q;
        cnt_d = cnt_q;
        lvl_d = db_q[gi];
        case (st_q)
          IDLE_LO: begin
            if (sync2_q[gi]) begin
              st_d  = WAIT_HI;
              cnt_d = CNT_W'(1);
            end
          end
          WAIT_HI: begin
            if (cnt_q == CNT_W'(DB_CYCLES)) begin
              st_d  = IDLE_HI;
              cnt_d = '0;
              lvl_d = 1'b1;
            end else if (!sync2_q[gi]) begin
              st_d  = IDLE_LO;
              cnt_d = '0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
          IDLE_HI: begin
            if (!sync2_q[gi]) begin
              st_d  = WAIT_LO;
              cnt_d = CNT_W'(1);
            end
          end
          WAIT_LO: begin
            if (cnt_q == CNT_W'(DB_CYCLES)) begin
              st_d  = IDLE_LO;
              cnt_d = '0;
              lvl_d = 1'b0;
            end else if (sync2_q[gi]) begin
              st_d  = IDLE_HI;
              cnt_d = '0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
          default: begin
            st_d  = IDLE_LO;
            cnt_d = '0;
          end
        endcase
      end

      assign db_d[gi] = lvl_d;
    end
  endgenerate

  pair_state_e p_q, p_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic a_q, a_d, b_q, b_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_q   <= P_IDLE;
      tmr_q <= '0;
      a_q   <= 1'b0;
      b_q   <= 1'b0;
    end else begin
      p_q   <= p_d;
      tmr_q <= tmr_d;
      a_q   <= a_d;
      b_q   <= b_d;
    end
  end

  // tmr_q holds cycles elapsed since the held event; the hold expires when it reaches COIN_WIN-1.
  always_comb begin
    p_d   = p_q;
    tmr_d = tmr_q;
    a_d   = 1'b0;
    b_d   = 1'b0;
    if (PULSE_MODE == 0) begin
      p_d   = P_IDLE;
      tmr_d = '0;
      a_d   = db_d[0];
      b_d   = db_d[1];
    end else if (COIN_WIN == 0) begin
      p_d   = P_IDLE;
      tmr_d = '0;
      a_d   = ev_q[0];
      b_d   = ev_q[1];
    end else begin
      case (p_q)
        P_IDLE: begin
          if (ev_q == 2'b11) begin
            a_d = 1'b1;
            b_d = 1'b1;
          end else if (ev_q[0]) begin
            if (COIN_WIN == 1) a_d = 1'b1;
            else begin
              p_d   = P_HOLD_A;
              tmr_d = TW'(1);
            end
          end else if (ev_q[1]) begin
            if (COIN_WIN == 1) b_d = 1'b1;
            else begin
              p_d   = P_HOLD_B;
              tmr_d = TW'(1);
            end
          end
        end
        P_HOLD_A: begin
          tmr_d = tmr_q + 1'b1;
          if (ev_q[1]) begin
            a_d = 1'b1;
            b_d = 1'b1;
            if (ev_q[0]) tmr_d = TW'(1);
            else begin
              p_d   = P_IDLE;
              tmr_d = '0;
            end
          end else if (ev_q[0]) begin
            a_d   = 1'b1;
            tmr_d = TW'(1);
          end else if (tmr_q == TW'(COIN_WIN - 1)) begin
            a_d   = 1'b1;
            p_d   = P_IDLE;
            tmr_d = '0;
          end
        end
        P_HOLD_B: begin
          tmr_d = tmr_q + 1'b1;
          if (ev_q[0]) begin
            a_d = 1'b1;
            b_d = 1'b1;
            if (ev_q[1]) tmr_d = TW'(1);
            else begin
              p_d   = P_IDLE;
              tmr_d = '0;
            end
          end else if (ev_q[1]) begin
            b_d   = 1'b1;
            tmr_d = TW'(1);
          end else if (tmr_q == TW'(COIN_WIN - 1)) begin
            b_d   = 1'b1;
            p_d   = P_IDLE;
            tmr_d = '0;
          end
        end
        default: begin
          p_d   = P_IDLE;
          tmr_d = '0;
        end
      endcase
    end
  end

  assign a    = a_q;
  assign b    = b_q;
  assign a_db = db_q[0];
  assign b_db = db_q[1];

endmodule
